// File: rtl/bnn_seq_lin_layer.sv
// bnn_seq_lin_layer: time-multiplexed binary fully-connected layer, PAR_OUT XNOR-popcount neurons per cycle
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i sync abort;
//   in_valid_i/in_ready_o/layer_i input frame; weights_i/threshold_i/sign_i per-neuron parameters;
//   out_valid_o/out_ready_i/layer_o/counts_o result; busy_o high while computing.
module bnn_seq_lin_layer #(
  parameter int ISIZE_FEAT = 192,
  parameter int OSIZE_FEAT = 64,
  parameter int N_BITCONV  = 8,
  parameter int PAR_OUT    = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [ISIZE_FEAT-1:0]                 layer_i,
  input  logic [OSIZE_FEAT-1:0][ISIZE_FEAT-1:0] weights_i,
  input  logic [OSIZE_FEAT-1:0][N_BITCONV-1:0]  threshold_i,
  input  logic [OSIZE_FEAT-1:0][1:0]            sign_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [OSIZE_FEAT-1:0]                 layer_o,
  output logic [OSIZE_FEAT-1:0][N_BITCONV-1:0]  counts_o,
  output logic                                  busy_o
);
  localparam int N_STEPS = (OSIZE_FEAT + PAR_OUT - 1) / PAR_OUT;
  localparam int KW = N_STEPS > 1 ? $clog2(N_STEPS) : 1;
  localparam logic [KW-1:0] LAST = KW'(N_STEPS - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [ISIZE_FEAT-1:0] in_q;
  logic [OSIZE_FEAT-1:0] layer_q, layer_d;
  logic [OSIZE_FEAT-1:0][N_BITCONV-1:0] counts_q, counts_d;
  logic [PAR_OUT-1:0][N_STEPS-1:0][ISIZE_FEAT-1:0] w_m;
  logic [PAR_OUT-1:0][ISIZE_FEAT-1:0] w_l;
  logic [PAR_OUT-1:0][N_BITCONV-1:0] c_l;
  logic acc;

  assign in_ready_o  = state_q == IDLE || (state_q == DONE && out_ready_i);
  assign acc         = in_valid_i && in_ready_o && !clear_i;
  assign out_valid_o = state_q == DONE;
  assign busy_o      = state_q == BUSY;
  assign layer_o     = layer_q;
  assign counts_o    = counts_q;

  // Each lane selects the weights of neuron k*PAR_OUT+l; lanes past OSIZE_FEAT in the last step see zeros.
  for (genvar l = 0; l < PAR_OUT; l++) begin : g_lane
    for (genvar s = 0; s < N_STEPS; s++) begin : g_step
      if (s * PAR_OUT + l < OSIZE_FEAT) begin : g_on
        assign w_m[l][s] = k_q == KW'(s) ? weights_i[s * PAR_OUT + l] : '0;
      end else begin : g_off
        assign w_m[l][s] = '0;
      end
    end
  end

  always_comb begin
    w_l = '0;
    c_l = '0;
    for (int l = 0; l < PAR_OUT; l++) begin
      for (int s = 0; s < N_STEPS; s++) w_l[l] = w_l[l] | w_m[l][s];
      c_l[l] = N_BITCONV'($countones(~(in_q ^ w_l[l])));
    end
  end

  // Neuron j is written only in its own step; sign[1] forces the output, sign[0] inverts cnt>=thr.
  for (genvar j = 0; j < OSIZE_FEAT; j++) begin : g_neu
    logic [N_BITCONV-1:0] c;
    logic upd;
    assign c   = c_l[j % PAR_OUT];
    assign upd = state_q == BUSY && !clear_i && k_q == KW'(j / PAR_OUT);
    assign counts_d[j] = upd ? c : counts_q[j];
    assign layer_d[j]  = upd ? (sign_i[j][1] ? sign_i[j][0] : sign_i[j][0] ^ (c >= threshold_i[j])) : layer_q[j];
  end

  always_comb begin
    state_d = clear_i ? IDLE
            : acc ? BUSY
            : state_q == BUSY && k_q == LAST ? DONE
            : state_q == BUSY || (state_q == DONE && !out_ready_i) ? state_q
            : IDLE;
    k_d = clear_i || acc || state_q != BUSY || k_q == LAST ? '0 : k_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      k_q      <= '0;
      in_q     <= '0;
      layer_q  <= '0;
      counts_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      in_q     <= acc ? layer_i : in_q;
      layer_q  <= layer_d;
      counts_q <= counts_d;
    end
  end
endmodule

// File: tb/tb_bnn_seq_lin_layer.sv
// tb_bnn_seq_lin_layer: directed self-checking bench for bnn_seq_lin_layer (default and small instances)
module tb_bnn_seq_lin_layer;
  localparam int IS = 192, OS = 64, NB = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid, busy;
  logic [IS-1:0] layer = '0;
  logic [OS-1:0][IS-1:0] w = '0;
  logic [OS-1:0][NB-1:0] thr = '0, cnt, ecnt;
  logic [OS-1:0][1:0] sg = '0;
  logic [OS-1:0] lo, elo;
  logic s_in_valid = 1'b0, s_out_ready = 1'b0, s_in_ready, s_out_valid, s_busy;
  logic [7:0] s_layer = '0;
  logic [5:0][7:0] s_w = '0;
  logic [5:0][3:0] s_thr = '0, s_cnt;
  logic [5:0][1:0] s_sg = '0;
  logic [5:0] s_lo;
  int vec = 0, err = 0;

  always #5 clk = ~clk;

  bnn_seq_lin_layer dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .layer_i(layer), .weights_i(w), .threshold_i(thr), .sign_i(sg), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .layer_o(lo), .counts_o(cnt), .busy_o(busy)
  );

  bnn_seq_lin_layer #(.ISIZE_FEAT(8), .OSIZE_FEAT(6), .N_BITCONV(4), .PAR_OUT(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .layer_i(s_layer), .weights_i(s_w), .threshold_i(s_thr), .sign_i(s_sg), .out_valid_o(s_out_valid),
    .out_ready_i(s_out_ready), .layer_o(s_lo), .counts_o(s_cnt), .busy_o(s_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(output int n);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (lo !== '0) begin err++; $display("FAIL reset_layer: got %h want 0", lo); end
    vec++; if (cnt !== '0) begin err++; $display("FAIL reset_counts: got %h want 0", cnt); end
    vec++; if (s_lo !== '0 || s_cnt !== '0 || s_in_ready !== 1'b1) begin err++; $display("FAIL reset_small: got lo %h cnt %h rdy %b want 0 0 1", s_lo, s_cnt, s_in_ready); end
  endtask

  task automatic test_all_ones();
    int n;
    layer = '1; w = '1; sg = '0;
    for (int j = 0; j < OS; j++) begin thr[j] = 8'd192; ecnt[j] = 8'd192; end
    frame(n);
    vec++; if (n !== 16) begin err++; $display("FAIL t1_latency: got %0d want 16", n); end
    vec++; if (lo !== {OS{1'b1}}) begin err++; $display("FAIL t1_layer: got %h want all ones", lo); end
    vec++; if (cnt !== ecnt) begin err++; $display("FAIL t1_counts: got %h want %h", cnt, ecnt); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL t1_busy: got %b want 0", busy); end
    handshake();
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL t1_drop_valid: got %b want 0", out_valid); end
    vec++; if (cnt !== ecnt || lo !== {OS{1'b1}}) begin err++; $display("FAIL t1_retain: got %h %h want %h all ones", cnt, lo, ecnt); end
  endtask

  task automatic test_sign_modes();
    int n;
    layer = '0; w = '1; ecnt = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < OS; j++) begin
        thr[j] = c == 3 ? 8'd128 : 8'd1;
        sg[j] = c == 0 ? 2'b01 : c == 2 ? (j % 2 == 1 ? 2'b11 : 2'b10) : 2'b00;
      end
      elo = c == 0 ? {OS{1'b1}} : c == 2 ? {32{2'b10}} : '0;
      frame(n);
      vec++; if (lo !== elo) begin err++; $display("FAIL t2_layer_mode%0d: got %h want %h", c, lo, elo); end
      vec++; if (cnt !== ecnt) begin err++; $display("FAIL t2_counts_mode%0d: got %h want 0", c, cnt); end
      handshake();
    end
  endtask

  task automatic test_thresholds();
    int n;
    layer = '1; w = '1;
    for (int j = 0; j < OS; j++) thr[j] = j % 2 == 1 ? 8'd193 : 8'd192;
    for (int c = 0; c < 2; c++) begin
      sg = c == 0 ? '0 : {OS{2'b01}};
      elo = c == 0 ? {32{2'b01}} : {32{2'b10}};
      frame(n);
      vec++; if (lo !== elo) begin err++; $display("FAIL thr_edge_sign%0d: got %h want %h", c, lo, elo); end
      handshake();
    end
  endtask

  task automatic test_lane_mapping();
    int n;
    logic [IS-1:0] ones;
    ones = '1;
    layer = '1; sg = '0;
    for (int j = 0; j < OS; j++) begin w[j] = ones >> (IS - j); thr[j] = 8'd32; ecnt[j] = NB'(j); end
    frame(n);
    vec++; if (n !== 16) begin err++; $display("FAIL map_latency: got %0d want 16", n); end
    vec++; if (cnt !== ecnt) begin err++; $display("FAIL map_counts: got %h want %h", cnt, ecnt); end
    vec++; if (lo !== 64'hFFFF_FFFF_0000_0000) begin err++; $display("FAIL map_layer: got %h want ffffffff00000000", lo); end
    handshake();
  endtask

  task automatic test_small();
    int n;
    for (int j = 0; j < 6; j++) s_w[j] = 8'hFF >> j;
    s_sg = '0;
    for (int f = 0; f < 2; f++) begin
      s_layer = f == 0 ? 8'hF0 : 8'h0F;
      for (int j = 0; j < 6; j++) s_thr[j] = f == 0 ? 4'd2 : 4'd8;
      s_in_valid = 1'b1;
      step();
      s_in_valid = 1'b0;
      n = 0;
      while (!s_out_valid && n < 100) begin step(); n++; end
      vec++; if (n !== 2) begin err++; $display("FAIL t3_latency%0d: got %0d want 2", f, n); end
      if (f == 0) begin
        vec++; if (s_cnt !== {4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4}) begin err++; $display("FAIL t3_counts0: got %h want 101234", s_cnt); end
        vec++; if (s_lo !== 6'b000111) begin err++; $display("FAIL t3_layer0: got %b want 000111", s_lo); end
      end else begin
        vec++; if (s_cnt !== {4'd7, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4}) begin err++; $display("FAIL t3_counts1: got %h want 787654", s_cnt); end
        vec++; if (s_lo !== 6'b010000) begin err++; $display("FAIL t3_layer1: got %b want 010000", s_lo); end
      end
      s_out_ready = 1'b1;
      step();
      s_out_ready = 1'b0;
      vec++; if (s_out_valid !== 1'b0) begin err++; $display("FAIL t3_drop_valid%0d: got %b want 0", f, s_out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    layer = '0;
    for (int j = 0; j < OS; j++) begin thr[j] = 8'd160; ecnt[j] = NB'(IS - j); end
    elo = 64'h0000_0001_FFFF_FFFF;
    frame(n);
    vec++; if (n !== 16) begin err++; $display("FAIL t5_latency: got %0d want 16", n); end
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin err++; $display("FAIL t5_hold_hs%0d: got rdy %b vld %b want 0 1", c, in_ready, out_valid); end
      vec++; if (cnt !== ecnt || lo !== elo) begin err++; $display("FAIL t5_hold_data%0d: got %h %h want %h %h", c, cnt, lo, ecnt, elo); end
    end
    in_valid = 1'b0;
    handshake();
    vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL t5_release: got vld %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    layer = '1; w = '1; sg = '0;
    for (int j = 0; j < OS; j++) begin thr[j] = 8'd192; ecnt[j] = 8'd192; end
    out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    vec++; if (busy !== 1'b1 || in_ready !== 1'b0) begin err++; $display("FAIL t4_busy: got busy %b rdy %b want 1 0", busy, in_ready); end
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    vec++; if (n !== 16) begin err++; $display("FAIL t4_latency_a: got %0d want 16", n); end
    vec++; if (cnt !== ecnt || in_ready !== 1'b1) begin err++; $display("FAIL t4_frame_a: got %h rdy %b want %h 1", cnt, in_ready, ecnt); end
    layer = '0;
    step();
    vec++; if (out_valid !== 1'b0 || busy !== 1'b1) begin err++; $display("FAIL t4_reaccept: got vld %b busy %b want 0 1", out_valid, busy); end
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    vec++; if (n !== 16) begin err++; $display("FAIL t4_latency_b: got %0d want 16", n); end
    vec++; if (cnt !== '0 || lo !== '0) begin err++; $display("FAIL t4_frame_b: got %h %h want 0 0", cnt, lo); end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL t4_end: got vld %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_clear_reset();
    logic seen;
    layer = '1; w = '1; sg = '0;
    for (int j = 0; j < OS; j++) begin thr[j] = 8'd192; ecnt[j] = j < 12 ? 8'd192 : 8'd0; end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    clear = 1'b1;
    in_valid = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin err++; $display("FAIL t6_clear_state: got busy %b vld %b rdy %b want 0 0 1", busy, out_valid, in_ready); end
    vec++; if (cnt !== ecnt || lo !== 64'hFFF) begin err++; $display("FAIL t6_clear_data: got %h %h want %h fff", cnt, lo, ecnt); end
    seen = 1'b0;
    repeat (20) begin step(); seen |= out_valid | busy; end
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL t6_no_result: got %b want 0", seen); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #3 rst_n = 1'b0;
    #1;
    vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL t6_rst_state: got vld %b busy %b want 0 0", out_valid, busy); end
    vec++; if (cnt !== '0 || lo !== '0) begin err++; $display("FAIL t6_rst_data: got %h %h want 0 0", cnt, lo); end
    step();
    rst_n = 1'b1;
    step();
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin err++; $display("FAIL t6_post_rst: got rdy %b vld %b want 1 0", in_ready, out_valid); end
    seen = 1'b0;
    repeat (20) begin step(); seen |= out_valid; end
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL t6_frame_lost: got %b want 0", seen); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    test_reset();
    test_all_ones();
    test_sign_modes();
    test_thresholds();
    test_lane_mapping();
    test_small();
    test_backpressure();
    test_back_to_back();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
